// File: rtl/sysid_checker.sv
// Purpose : Avalon-MM read master that fetches system-ID word 0 (ID) and word 1 (timestamp) and checks them.
// Latency : start at edge k -> read visible from k+1; zero-wait / 1-cycle-latency slave gives done from k+5.
// Backpr. : holds avm_read/avm_address stable under avm_waitrequest; a per-read counter aborts to DONE on timeout.
//
// Ports:
//   clock, reset_n (async, active-low)        start: one-cycle check request (ignored while busy)
//   avm_address/avm_read -> slave             avm_waitrequest/avm_readdatavalid/avm_readdata <- slave
//   busy, done                                check in progress / check finished (held until next start)
//   id_value, ts_value                        captured words 0 and 1
//   id_match, ts_match, pass, timeout_err     registered results, valid together with done
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1453159006,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_match,
  output logic        ts_match,
  output logic        pass,
  output logic        timeout_err
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic        start_pend;
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_cnt_inc;
  logic        in_xfer;
  logic        tmo_hit;
  logic        go;
  logic        id_cap;
  logic        ts_cap;

  // Shared decode. The timeout wins over any same-cycle acceptance or
  // response: the read budget is exactly TIMEOUT_CYCLES cycles.
  always_comb begin
    in_xfer     = (state == ID_REQ) || (state == ID_WAIT) ||
                  (state == TS_REQ) || (state == TS_WAIT);
    tmo_cnt_inc = tmo_cnt + 16'd1;
    tmo_hit     = in_xfer && (tmo_cnt_inc == TMO_LIMIT);
    go          = (start || start_pend) && ((state == IDLE) || (state == DONE));
    id_cap      = (state == ID_WAIT) && avm_readdatavalid && !tmo_hit;
    ts_cap      = (state == TS_WAIT) && avm_readdatavalid && !tmo_hit;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (go) state_nxt = ID_REQ;
      ID_REQ: begin
        if (tmo_hit)               state_nxt = DONE;
        else if (!avm_waitrequest) state_nxt = ID_WAIT;
      end
      ID_WAIT: begin
        if (tmo_hit)     state_nxt = DONE;
        else if (id_cap) state_nxt = TS_REQ;
      end
      TS_REQ: begin
        if (tmo_hit)               state_nxt = DONE;
        else if (!avm_waitrequest) state_nxt = TS_WAIT;
      end
      TS_WAIT: begin
        if (tmo_hit || ts_cap) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are pure state decodes, so they never glitch on slave inputs.
  always_comb begin
    avm_read    = (state == ID_REQ) || (state == TS_REQ);
    avm_address = (state == TS_REQ);
  end

  // Status, capture and timeout counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_pend  <= AUTO_START;
      tmo_cnt     <= 16'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      pass        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // The pending auto-start is consumed on the first edge out of reset.
      start_pend <= 1'b0;
      if (go) begin
        tmo_cnt     <= 16'd0;
        busy        <= 1'b1;
        done        <= 1'b0;
        id_value    <= 32'd0;
        ts_value    <= 32'd0;
        id_match    <= 1'b0;
        ts_match    <= 1'b0;
        pass        <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        // Capturing word 0 is the entry into TS_REQ: restart the budget there.
        if (in_xfer) tmo_cnt <= id_cap ? 16'd0 : tmo_cnt_inc;
        if (id_cap) id_value <= avm_readdata;
        if (ts_cap) begin
          // ts_value is loaded on this same edge, so compare the bus directly.
          ts_value <= avm_readdata;
          done     <= 1'b1;
          busy     <= 1'b0;
          id_match <= (id_value == EXPECTED_ID);
          ts_match <= (avm_readdata == EXPECTED_TIMESTAMP);
          pass     <= (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
        end
        if (tmo_hit) begin
          done        <= 1'b1;
          busy        <= 1'b0;
          timeout_err <= 1'b1;
          id_match    <= 1'b0;
          ts_match    <= 1'b0;
          pass        <= 1'b0;
        end
      end
    end
  end

endmodule
